mii_rx_deframer: RTL
====================

// Module: mii_rx_deframer
// PURPOSE
// Receive-side counterpart of the MAC/MII transmit path: consumes the 64-bit data / 8-bit ctrl MII word stream,
// finds START and TERMINATE, strips preamble/SFD and FCS, checks CRC-32 and frame length. Emits payload beats
// (dest addr .. last payload byte) with byte-keep, SOF/EOF markers, error flags and frame counters.
// No backpressure: line-rate, one word per clk.
// PARAMETERS
// IDLE_CODE 8'h07 ; START_CODE 8'hFB ; TERM_CODE 8'hFD ; PREAMBLE_CODE 8'h55 ; SFD_CODE 8'hD5 -- control/preamble chars
// MIN_FRAME_BYTES 64 -- minimum bytes after SFD up to TERMINATE, FCS included
// MAX_FRAME_BYTES 1518 -- maximum bytes after SFD up to TERMINATE, FCS included
// CNT_WIDTH 32 -- width of frame counters
// PORTS
// clk           in   1         single clock, all logic on posedge
// i_rst         in   1         synchronous, active-high reset
// i_rx_data     in   64        MII data; lane k = bits [8k+7:8k], lane 0 first on wire
// i_rx_ctrl     in   8         bit k=1 -> lane k is a control char
// o_data        out  64        payload beat, same lane order
// o_keep        out  8         valid lanes, contiguous from lane 0
// o_valid       out  1         beat valid
// o_sof         out  1         first beat of frame
// o_eof         out  1         last beat of frame
// o_err         out  1         with o_eof: frame bad (fcs|len|ctrl)
// o_fcs_err     out  1         1-cycle pulse at frame close: CRC residue mismatch
// o_len_err     out  1         1-cycle pulse: under MIN or over MAX
// o_ctrl_err    out  1         1-cycle pulse: illegal control char / START inside frame
// o_pre_err     out  1         1-cycle pulse: START word with bad preamble/SFD
// o_good_frames out  CNT_WIDTH frames closed with o_err=0, saturating
// o_bad_frames  out  CNT_WIDTH frames closed with error, saturating
// BEHAVIOUR
// - Reset: all outputs 0, counters 0, state IDLE, hold register empty, CRC = 32'hFFFFFFFF.
// - Valid START word: ctrl=8'h01, lane0=START_CODE, lanes1-6=PREAMBLE_CODE, lane7=SFD_CODE. START in lane 0 only.
// - States: IDLE, DATA, FLUSH, DROP.
// - IDLE: valid START -> DATA, reset byte count/CRC/hold. ctrl[0]=1 & lane0=START but rest wrong -> o_pre_err, stay IDLE.
//   Anything else ignored.
// - DATA, ctrl=0: CRC over 8 bytes, count+=8. Register prior held word as full beat (keep 8'hFF), hold current word.
//   Output = word sampled one edge earlier (latency 2 clk from presentation).
// - TERMINATE in lane k: ctrl[k]=1, lane k=TERM_CODE, lanes<k ctrl=0, lanes>k ctrl=1 IDLE_CODE. Lanes<k are frame bytes.
//   Final count = count+k.
//   k<4: held word emitted eof, keep=(1<<(4+k))-1; back to IDLE.
//   k=4: held word emitted eof, keep=8'hFF; IDLE.
//   k>4: held word emitted non-eof keep=8'hFF; -> FLUSH; next clk emit lanes 0..k-5 eof, keep=(1<<(k-4))-1; FLUSH->IDLE.
//   A valid START seen in FLUSH is accepted (FLUSH->DATA).
//   If no word held yet (terminate in first data word): no beats, o_len_err pulse, bad_frames+1.
// - CRC: reflected CRC-32 (poly 32'hEDB88320), init FFFFFFFF, lanes in order, over all bytes incl FCS.
//   Good iff final register == 32'hDEBB20E3.
// - Close checks: count<MIN or >MAX -> len_err; residue bad -> fcs_err. Pulses coincide with eof beat.
//   o_err=OR; exactly one counter +1.
// - Oversize: count exceeds MAX_FRAME_BYTES in DATA -> emit held word eof,o_err=1, o_len_err -> DROP.
//   DROP discards until TERMINATE (->IDLE) or START (->DATA, new frame).
// - DATA, other ctrl pattern (idle, error char, misplaced TERM): held word emitted eof,o_err=1, o_ctrl_err -> IDLE.
//   Valid START in DATA: same closure, new frame begins from that word.
// - Every frame with o_sof gets exactly one o_eof; o_sof and o_eof may share a beat. o_sof/o_eof/o_err/o_keep=0
//   when o_valid=0.
// - i_rst mid-frame: next clk IDLE, no eof emitted, counters cleared, partial frame lost.
// TESTING
// 1. START + 8 data words (64 B, valid FCS) + TERM lane0 -> 8 beats, sof on 1st, eof keep 8'h0F, o_err=0, good=1.
// 2. 65 B (TERM lane1) -> 8 beats last keep 8'h1F; 68 B (TERM lane4) -> 8 beats last keep FF.
//    70 B (TERM lane6) -> 9 beats, FLUSH beat keep 8'h03 eof.
// 3. 64 B frame, one payload byte flipped -> eof with o_err=1, o_fcs_err pulse on eof, bad=1, good unchanged.
// 4. 40 B frame valid CRC -> o_len_err; 1600 B frame -> eof/err at byte 1519 crossing, DROP until TERM, bad+1.
// 5. IDLE word mid-frame -> held beat eof, o_ctrl_err; START with lane3=8'h00 -> o_pre_err, no beats.
// 6. Back-to-back: TERM lane6 then START next word -> flush beat and new frame both correct.
//    i_rst mid-frame -> all outputs 0 next clk.

Source files
------------

// File: rtl/mii_rx_deframer.sv
// Receive deframer for a 64-bit MII word stream.
// Strips preamble/SFD and FCS, checks CRC-32 and length, and emits payload beats with keep and frame markers.
module mii_rx_deframer #(
    parameter logic [7:0]  IDLE_CODE       = 8'h07,
    parameter logic [7:0]  START_CODE      = 8'hFB,
    parameter logic [7:0]  TERM_CODE       = 8'hFD,
    parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
    parameter logic [7:0]  SFD_CODE        = 8'hD5,
    parameter int unsigned MIN_FRAME_BYTES = 64,
    parameter int unsigned MAX_FRAME_BYTES = 1518,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic [63:0]          i_rx_data,
    input  logic [7:0]           i_rx_ctrl,
    output logic [63:0]          o_data,
    output logic [7:0]           o_keep,
    output logic                 o_valid,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic                 o_err,
    output logic                 o_fcs_err,
    output logic                 o_len_err,
    output logic                 o_ctrl_err,
    output logic                 o_pre_err,
    output logic [CNT_WIDTH-1:0] o_good_frames,
    output logic [CNT_WIDTH-1:0] o_bad_frames
);

    localparam int unsigned BCNT_W = $clog2(MAX_FRAME_BYTES + 16);
    localparam logic [BCNT_W-1:0] MIN_B = BCNT_W'(MIN_FRAME_BYTES);
    localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_FRAME_BYTES);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // mask of the lowest n lanes, n in 0..8
    function automatic logic [7:0] lane_mask(input logic [3:0] n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic [1:0]        state, state_n;
    logic [63:0]       hold_data, hold_data_n, flush_data, flush_data_n;
    logic              hold_vld, hold_vld_n, sof_pend, sof_pend_n;
    logic [7:0]        flush_keep, flush_keep_n;
    logic              flush_fcs, flush_fcs_n, flush_len, flush_len_n;
    logic [BCNT_W-1:0] byte_cnt, byte_cnt_n, final_cnt, wide_cnt;
    logic [31:0]       crc, crc_n;
    logic [31:0]       crc_chain [9];

    logic [63:0] data_n;
    logic [7:0]  keep_n;
    logic        valid_n, sof_n, eof_n, err_n, fcs_err_n, len_err_n, ctrl_err_n, pre_err_n;
    logic        good_inc, bad_inc, emit_hold, open_frame, len_bad, fcs_bad;

    logic        is_start, start_ish, term_hit;
    logic [2:0]  term_k;
    logic [7:0]  idle_lane, term_ok;
    logic [6:1]  pre_lane;

    // word classification and per-lane CRC chain
    always_comb begin
        for (int i = 1; i < 7; i++) pre_lane[i] = (i_rx_data[8*i +: 8] == PREAMBLE_CODE);
        for (int i = 0; i < 8; i++) idle_lane[i] = (i_rx_data[8*i +: 8] == IDLE_CODE);
        start_ish = i_rx_ctrl[0] && (i_rx_data[7:0] == START_CODE);
        is_start  = (i_rx_ctrl == 8'h01) && (i_rx_data[7:0] == START_CODE) &&
                    (&pre_lane) && (i_rx_data[63:56] == SFD_CODE);
        term_hit = 1'b0;
        term_k   = '0;
        for (int k = 0; k < 8; k++) begin
            term_ok[k] = i_rx_ctrl[k] && (i_rx_data[8*k +: 8] == TERM_CODE) &&
                         ((i_rx_ctrl & lane_mask(4'(k))) == 8'h00) &&
                         ((i_rx_ctrl | lane_mask(4'(k + 1))) == 8'hFF) &&
                         ((idle_lane | lane_mask(4'(k + 1))) == 8'hFF);
            if (term_ok[k]) begin
                term_hit = 1'b1;
                term_k   = 3'(k);
            end
        end
        crc_chain[0] = crc;
        for (int i = 0; i < 8; i++) crc_chain[i+1] = crc_byte(crc_chain[i], i_rx_data[8*i +: 8]);
    end

    // next-state and next-output logic
    always_comb begin
        state_n      = state;
        hold_data_n  = hold_data;
        hold_vld_n   = hold_vld;
        sof_pend_n   = sof_pend;
        flush_data_n = flush_data;
        flush_keep_n = flush_keep;
        flush_fcs_n  = flush_fcs;
        flush_len_n  = flush_len;
        byte_cnt_n   = byte_cnt;
        crc_n        = crc;
        data_n       = '0;
        keep_n       = '0;
        valid_n      = 1'b0;
        sof_n        = 1'b0;
        eof_n        = 1'b0;
        err_n        = 1'b0;
        fcs_err_n    = 1'b0;
        len_err_n    = 1'b0;
        ctrl_err_n   = 1'b0;
        pre_err_n    = 1'b0;
        good_inc     = 1'b0;
        bad_inc      = 1'b0;
        emit_hold    = 1'b0;
        open_frame   = 1'b0;
        wide_cnt     = byte_cnt + BCNT_W'(8);
        final_cnt    = byte_cnt + BCNT_W'(term_k);
        len_bad      = (final_cnt < MIN_B) || (final_cnt > MAX_B);
        fcs_bad      = (crc_chain[4'(term_k)] != CRC_RESIDUE);

        case (state)
            S_IDLE, S_FLUSH: begin
                if (state == S_FLUSH) begin
                    valid_n   = 1'b1;
                    data_n    = flush_data;
                    keep_n    = flush_keep;
                    eof_n     = 1'b1;
                    err_n     = flush_fcs | flush_len;
                    fcs_err_n = flush_fcs;
                    len_err_n = flush_len;
                    good_inc  = !(flush_fcs | flush_len);
                    bad_inc   = flush_fcs | flush_len;
                end
                state_n = S_IDLE;
                if (is_start)       open_frame = 1'b1;
                else if (start_ish) pre_err_n  = 1'b1;
            end
            S_DATA: begin
                if (i_rx_ctrl == 8'h00) begin
                    byte_cnt_n = wide_cnt;
                    crc_n      = crc_chain[8];
                    emit_hold  = hold_vld;
                    keep_n     = hold_vld ? 8'hFF : 8'h00;
                    if (wide_cnt > MAX_B) begin
                        eof_n      = hold_vld;
                        err_n      = hold_vld;
                        len_err_n  = 1'b1;
                        bad_inc    = 1'b1;
                        hold_vld_n = 1'b0;
                        state_n    = S_DROP;
                    end else begin
                        hold_data_n = i_rx_data;
                        hold_vld_n  = 1'b1;
                    end
                end else if (term_hit) begin
                    state_n    = S_IDLE;
                    hold_vld_n = 1'b0;
                    if (!hold_vld) begin
                        len_err_n = 1'b1;
                        bad_inc   = 1'b1;
                    end else begin
                        emit_hold = 1'b1;
                        keep_n    = lane_mask(4'(term_k) + 4'd4);
                        if (term_k < 3'd5) begin
                            eof_n     = 1'b1;
                            err_n     = len_bad | fcs_bad;
                            fcs_err_n = fcs_bad;
                            len_err_n = len_bad;
                            good_inc  = !(len_bad | fcs_bad);
                            bad_inc   = len_bad | fcs_bad;
                        end else begin
                            flush_data_n = i_rx_data;
                            flush_keep_n = lane_mask(4'(term_k) - 4'd4);
                            flush_fcs_n  = fcs_bad;
                            flush_len_n  = len_bad;
                            state_n      = S_FLUSH;
                        end
                    end
                end else begin
                    // control anomaly (or a fresh START) closes the frame as bad
                    emit_hold  = hold_vld;
                    keep_n     = hold_vld ? 8'hFF : 8'h00;
                    eof_n      = hold_vld;
                    err_n      = hold_vld;
                    ctrl_err_n = 1'b1;
                    bad_inc    = 1'b1;
                    hold_vld_n = 1'b0;
                    state_n    = S_IDLE;
                    open_frame = is_start;
                end
            end
            S_DROP: begin
                if (is_start)      open_frame = 1'b1;
                else if (term_hit) state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (emit_hold) begin
            valid_n    = 1'b1;
            data_n     = hold_data;
            sof_n      = sof_pend;
            sof_pend_n = 1'b0;
        end
        if (open_frame) begin
            state_n    = S_DATA;
            byte_cnt_n = '0;
            crc_n      = CRC_INIT;
            hold_vld_n = 1'b0;
            sof_pend_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            hold_data     <= '0;
            hold_vld      <= 1'b0;
            sof_pend      <= 1'b0;
            flush_data    <= '0;
            flush_keep    <= '0;
            flush_fcs     <= 1'b0;
            flush_len     <= 1'b0;
            byte_cnt      <= '0;
            crc           <= CRC_INIT;
            o_data        <= '0;
            o_keep        <= '0;
            o_valid       <= 1'b0;
            o_sof         <= 1'b0;
            o_eof         <= 1'b0;
            o_err         <= 1'b0;
            o_fcs_err     <= 1'b0;
            o_len_err     <= 1'b0;
            o_ctrl_err    <= 1'b0;
            o_pre_err     <= 1'b0;
            o_good_frames <= '0;
            o_bad_frames  <= '0;
        end else begin
            hold_data  <= hold_data_n;
            hold_vld   <= hold_vld_n;
            sof_pend   <= sof_pend_n;
            flush_data <= flush_data_n;
            flush_keep <= flush_keep_n;
            flush_fcs  <= flush_fcs_n;
            flush_len  <= flush_len_n;
            byte_cnt   <= byte_cnt_n;
            crc        <= crc_n;
            o_data     <= data_n;
            o_keep     <= keep_n;
            o_valid    <= valid_n;
            o_sof      <= sof_n;
            o_eof      <= eof_n;
            o_err      <= err_n;
            o_fcs_err  <= fcs_err_n;
            o_len_err  <= len_err_n;
            o_ctrl_err <= ctrl_err_n;
            o_pre_err  <= pre_err_n;
            if (good_inc && (o_good_frames != '1)) o_good_frames <= o_good_frames + CNT_WIDTH'(1);
            if (bad_inc && (o_bad_frames != '1))   o_bad_frames  <= o_bad_frames + CNT_WIDTH'(1);
        end
    end

endmodule
